bin_sched: RTL



---
 rtl/bin_sched_if.sv | 41 ++++
 rtl/bin_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_sched_if.sv
// Handshake bundle between the bin scheduler and its environment
// (solve request, load/core/write-back/backtrack units and the result flags).
interface bin_sched_if #(
    parameter int WIDTH_BIN_ID = 10,
    parameter int WIDTH_CNT    = 32
);
    logic                    start_solve_i;
    logic [WIDTH_BIN_ID-1:0] num_bins_i;
    logic                    start_load_o;
    logic [WIDTH_BIN_ID-1:0] load_bin_id_o;
    logic                    done_load_i;
    logic                    start_core_o;
    logic                    done_core_i;
    logic                    sat_i;
    logic                    unsat_i;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_num_i;
    logic                    start_wb_o;
    logic                    done_wb_i;
    logic                    apply_bkt_o;
    logic                    done_bkt_i;
    logic [WIDTH_BIN_ID-1:0] cur_bin_o;
    logic [WIDTH_CNT-1:0]    run_cnt_o;
    logic                    done_o;
    logic                    global_sat_o;
    logic                    global_unsat_o;
    logic                    error_o;

    modport slave (
        input  start_solve_i, num_bins_i, done_load_i, done_core_i, sat_i, unsat_i,
               bkt_bin_num_i, done_wb_i, done_bkt_i,
        output start_load_o, load_bin_id_o, start_core_o, start_wb_o, apply_bkt_o,
               cur_bin_o, run_cnt_o, done_o, global_sat_o, global_unsat_o, error_o
    );

    modport master (
        output start_solve_i, num_bins_i, done_load_i, done_core_i, sat_i, unsat_i,
               bkt_bin_num_i, done_wb_i, done_bkt_i,
        input  start_load_o, load_bin_id_o, start_core_o, start_wb_o, apply_bkt_o,
               cur_bin_o, run_cnt_o, done_o, global_sat_o, global_unsat_o, error_o
    );
endinterface

// File: rtl/bin_sched.sv
// Bin-by-bin SAT scheduler: load, run core, write back, then advance or backtrack
// until a global SAT/UNSAT verdict is reached.
module bin_sched #(
    parameter int WIDTH_BIN_ID = 10,
    parameter int WIDTH_CNT    = 32
) (
    input logic       clk,
    input logic       rst,
    bin_sched_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CORE   = 3'd2,
        S_WB     = 3'd3,
        S_DECIDE = 3'd4,
        S_BKT    = 3'd5,
        S_FIN    = 3'd6
    } state_t;

    localparam logic [WIDTH_BIN_ID-1:0] BIN_ZERO = {WIDTH_BIN_ID{1'b0}};
    localparam logic [WIDTH_BIN_ID-1:0] BIN_ONE  = {{(WIDTH_BIN_ID-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_BIN_ID-1:0] BIN_ALL  = {WIDTH_BIN_ID{1'b1}};
    localparam logic [WIDTH_CNT-1:0]    CNT_ZERO = {WIDTH_CNT{1'b0}};
    localparam logic [WIDTH_CNT-1:0]    CNT_ONE  = {{(WIDTH_CNT-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_CNT-1:0]    CNT_ALL  = {WIDTH_CNT{1'b1}};

    state_t                  state_r, state_s;
    logic                    entry_r;
    logic                    load_prev_r, core_prev_r, wb_prev_r, bkt_prev_r;
    logic                    load_edge_s, core_edge_s, wb_edge_s, bkt_edge_s;
    logic [WIDTH_BIN_ID-1:0] num_bins_r, cur_bin_r, cur_bin_s, bkt_r;
    logic                    sat_r, unsat_r;
    logic                    set_sat_s, set_unsat_s, set_err_s;
    logic                    res_sat_r, res_unsat_r, res_err_r;
    logic                    start_load_r, start_core_r, start_wb_r, apply_bkt_r;
    logic [WIDTH_CNT-1:0]    run_cnt_r;
    logic                    done_r, global_sat_r, global_unsat_r, error_r;

    // The done level seen in a state's first cycle is only a baseline, so a sticky
    // done left over from a previous run never completes the state.
    assign load_edge_s = (state_r == S_LOAD) && !entry_r && bus.done_load_i && !load_prev_r;
    assign core_edge_s = (state_r == S_CORE) && !entry_r && bus.done_core_i && !core_prev_r;
    assign wb_edge_s   = (state_r == S_WB)   && !entry_r && bus.done_wb_i   && !wb_prev_r;
    assign bkt_edge_s  = (state_r == S_BKT)  && !entry_r && bus.done_bkt_i  && !bkt_prev_r;

    // State register and state-entry flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
            entry_r <= 1'b0;
        end else begin
            state_r <= state_s;
            entry_r <= (state_s != state_r);
        end
    end

    // Next-state, next bin and verdict selection
    always_comb begin
        state_s     = state_r;
        cur_bin_s   = cur_bin_r;
        set_sat_s   = 1'b0;
        set_unsat_s = 1'b0;
        set_err_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.start_solve_i) begin
                    cur_bin_s = BIN_ZERO;
                    if (bus.num_bins_i == BIN_ZERO) begin
                        state_s   = S_FIN;
                        set_sat_s = 1'b1;
                    end else begin
                        state_s = S_LOAD;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (load_edge_s) state_s = S_CORE;
                else             state_s = S_LOAD;
            end
            S_CORE: begin
                if (core_edge_s) state_s = S_WB;
                else             state_s = S_CORE;
            end
            S_WB: begin
                if (wb_edge_s) state_s = S_DECIDE;
                else           state_s = S_WB;
            end
            S_DECIDE: begin
                if (sat_r) begin
                    if (cur_bin_r == (num_bins_r - BIN_ONE)) begin
                        state_s   = S_FIN;
                        set_sat_s = 1'b1;
                    end else begin
                        state_s   = S_LOAD;
                        cur_bin_s = cur_bin_r + BIN_ONE;
                    end
                end else if (unsat_r && (bkt_r == BIN_ALL)) begin
                    state_s     = S_FIN;
                    set_unsat_s = 1'b1;
                end else if (unsat_r && (bkt_r == cur_bin_r)) begin
                    state_s = S_LOAD;
                end else if (unsat_r && (bkt_r < cur_bin_r)) begin
                    state_s = S_BKT;
                end else begin
                    // Forward backtrack target, or no verdict at all
                    state_s     = S_FIN;
                    set_unsat_s = 1'b1;
                    set_err_s   = 1'b1;
                end
            end
            S_BKT: begin
                if (bkt_edge_s) begin
                    state_s   = S_LOAD;
                    cur_bin_s = bkt_r;
                end else begin
                    state_s = S_BKT;
                end
            end
            S_FIN:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Datapath, edge history and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            load_prev_r    <= 1'b0;
            core_prev_r    <= 1'b0;
            wb_prev_r      <= 1'b0;
            bkt_prev_r     <= 1'b0;
            num_bins_r     <= BIN_ZERO;
            cur_bin_r      <= BIN_ZERO;
            bkt_r          <= BIN_ZERO;
            sat_r          <= 1'b0;
            unsat_r        <= 1'b0;
            res_sat_r      <= 1'b0;
            res_unsat_r    <= 1'b0;
            res_err_r      <= 1'b0;
            start_load_r   <= 1'b0;
            start_core_r   <= 1'b0;
            start_wb_r     <= 1'b0;
            apply_bkt_r    <= 1'b0;
            run_cnt_r      <= CNT_ZERO;
            done_r         <= 1'b0;
            global_sat_r   <= 1'b0;
            global_unsat_r <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            load_prev_r  <= bus.done_load_i;
            core_prev_r  <= bus.done_core_i;
            wb_prev_r    <= bus.done_wb_i;
            bkt_prev_r   <= bus.done_bkt_i;
            cur_bin_r    <= cur_bin_s;
            res_sat_r    <= set_sat_s;
            res_unsat_r  <= set_unsat_s;
            res_err_r    <= set_err_s;
            start_load_r <= (state_r == S_LOAD) && entry_r;
            start_core_r <= (state_r == S_CORE) && entry_r;
            start_wb_r   <= (state_r == S_WB)   && entry_r;
            apply_bkt_r  <= (state_r == S_BKT)  && entry_r;

            if ((state_r == S_IDLE) && bus.start_solve_i) begin
                num_bins_r     <= bus.num_bins_i;
                run_cnt_r      <= CNT_ZERO;
                sat_r          <= 1'b0;
                unsat_r        <= 1'b0;
                done_r         <= 1'b0;
                global_sat_r   <= 1'b0;
                global_unsat_r <= 1'b0;
                error_r        <= 1'b0;
            end

            if ((state_r == S_CORE) && entry_r && (run_cnt_r != CNT_ALL)) begin
                run_cnt_r <= run_cnt_r + CNT_ONE;
            end

            if (core_edge_s) begin
                sat_r   <= bus.sat_i & ~bus.unsat_i;
                unsat_r <= bus.unsat_i;
                bkt_r   <= bus.bkt_bin_num_i;
            end

            if (state_r == S_FIN) begin
                done_r         <= 1'b1;
                global_sat_r   <= res_sat_r;
                global_unsat_r <= res_unsat_r;
                error_r        <= res_err_r;
            end
        end
    end

    assign bus.start_load_o   = start_load_r;
    assign bus.load_bin_id_o  = cur_bin_r;
    assign bus.start_core_o   = start_core_r;
    assign bus.start_wb_o     = start_wb_r;
    assign bus.apply_bkt_o    = apply_bkt_r;
    assign bus.cur_bin_o      = cur_bin_r;
    assign bus.run_cnt_o      = run_cnt_r;
    assign bus.done_o         = done_r;
    assign bus.global_sat_o   = global_sat_r;
    assign bus.global_unsat_o = global_unsat_r;
    assign bus.error_o        = error_r;
endmodule
